// File: rtl/rf_bist_controller.sv
// Two-pass write/read-back march over the 32 x 64-bit register file.
// Register 31 is written too and must still read back as zero.
module rf_bist_controller (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [63:0] BusA,
    input  logic [63:0] BusB,
    output logic [4:0]  RA,
    output logic [4:0]  RB,
    output logic [4:0]  RW,
    output logic [63:0] BusW,
    output logic        RegWr,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [6:0]  FailCount,
    output logic [4:0]  FirstFailReg
);

    localparam logic [63:0] PATTERN = 64'hF0F0_F0F0_0F0F_0F00;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        p_q, p_d;
    logic [4:0]  i_q, i_d;
    logic [6:0]  fail_q, fail_d;
    logic [4:0]  first_q, first_d;
    logic        mis_a, mis_b;

    function automatic logic [63:0] exp_w(input logic p, input logic [4:0] r);
        logic [63:0] sum;
        sum = PATTERN + {59'd0, r};
        return p ? ~sum : sum;
    endfunction

    function automatic logic [63:0] exp_r(input logic p, input logic [4:0] r);
        return (r == 5'd31) ? 64'd0 : exp_w(p, r);
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            p_q     <= 1'b0;
            i_q     <= 5'd0;
            fail_q  <= 7'd0;
            first_q <= 5'd0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            i_q     <= i_d;
            fail_q  <= fail_d;
            first_q <= first_d;
        end
    end

    // Port drives decode straight from registered state, so they only move on rising edges.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        i_d     = i_q;
        fail_d  = fail_q;
        first_d = first_q;
        RA      = 5'd0;
        RB      = 5'd0;
        RW      = 5'd0;
        BusW    = 64'd0;
        RegWr   = 1'b0;
        Busy    = 1'b0;
        mis_a   = 1'b0;
        mis_b   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d = S_WRITE;
                    p_d     = 1'b0;
                    i_d     = 5'd0;
                    fail_d  = 7'd0;
                    first_d = 5'd0;
                end
            end
            S_WRITE: begin
                Busy  = 1'b1;
                RegWr = 1'b1;
                RW    = i_q;
                BusW  = exp_w(p_q, i_q);
                i_d   = i_q + 5'd1;
                if (i_q == 5'd31) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                Busy   = 1'b1;
                RA     = {i_q[3:0], 1'b0};
                RB     = {i_q[3:0], 1'b1};
                mis_a  = (BusA != exp_r(p_q, RA));
                mis_b  = (BusB != exp_r(p_q, RB));
                fail_d = fail_q + 7'(mis_a) + 7'(mis_b);
                // RA holds the lower index, so it is reported when both buses fail together.
                if (fail_q == 7'd0 && (mis_a || mis_b)) begin
                    first_d = mis_a ? RA : RB;
                end
                i_d = i_q + 5'd1;
                if (i_q == 5'd15) begin
                    i_d = 5'd0;
                    if (p_q) begin
                        state_d = S_DONE;
                    end else begin
                        p_d     = 1'b1;
                        state_d = S_WRITE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Done         = (state_q == S_DONE);
    assign Pass         = Done && (fail_q == 7'd0);
    assign FailCount    = fail_q;
    assign FirstFailReg = first_q;

endmodule

// File: tb/tb_rf_bist_controller.sv
// Bench for rf_bist_controller: register file model with injectable faults and a
// pass/register-level reference for run timing, port drives and the final verdict.
module tb_rf_bist_controller;

    localparam logic [63:0] PAT = 64'hF0F0_F0F0_0F0F_0F00;
    // fault modes: 0 none, 1 stuck bit (rr,bb,vv), 2 reg 31 writable, 3 writes ignored
    int mode, rr, bb, vv;
    int vectors, miscompares;

    logic        Clk, Reset, Start;
    logic [63:0] BusA, BusB, BusW;
    logic [4:0]  RA, RB, RW, FirstFailReg;
    logic        RegWr, Busy, Done, Pass;
    logic [6:0]  FailCount;
    logic        rf_clr;
    logic [63:0] rf_mem [32];

    rf_bist_controller dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .BusA(BusA), .BusB(BusB),
        .RA(RA), .RB(RB), .RW(RW), .BusW(BusW), .RegWr(RegWr), .Busy(Busy),
        .Done(Done), .Pass(Pass), .FailCount(FailCount), .FirstFailReg(FirstFailReg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [63:0] wdat(input int p, input int r);
        logic [63:0] s;
        s = PAT + 64'(r);
        return (p != 0) ? ~s : s;
    endfunction

    function automatic logic [63:0] view(input int m, input int sr, input int sb, input int sv,
                                         input logic [63:0] v, input int r);
        logic [63:0] x;
        x = v;
        if (r == 31 && m != 2) return 64'd0;
        if (m == 1 && r == sr) x[sb] = sv[0];
        return x;
    endfunction

    always @(negedge Clk) begin
        if (rf_clr) begin
            for (int j = 0; j < 32; j++) rf_mem[j] <= 64'd0;
        end else if (RegWr && mode != 3 && (RW != 5'd31 || mode == 2)) begin
            rf_mem[RW] <= BusW;
        end
    end

    assign BusA = view(mode, rr, bb, vv, rf_mem[RA], int'(RA));
    assign BusB = view(mode, rr, bb, vv, rf_mem[RB], int'(RB));

    // Reference: replay both passes register by register on a cleared file.
    function automatic void predict(input int m, input int sr, input int sb, input int sv,
                                    output int fc, output int ff);
        logic [63:0] mem [32];
        logic [63:0] e;
        fc = 0;
        ff = 0;
        for (int r = 0; r < 32; r++) mem[r] = 64'd0;
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < 32; r++)
                if (m != 3 && (r != 31 || m == 2)) mem[r] = wdat(p, r);
            for (int r = 0; r < 32; r++) begin
                e = (r == 31) ? 64'd0 : wdat(p, r);
                if (view(m, sr, sb, sv, mem[r], r) !== e) begin
                    if (fc == 0) ff = r;
                    fc++;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_rf();
        rf_clr = 1'b1;
        tick();
        rf_clr = 1'b0;
    endtask

    // Walks one run from the current cycle; cycle c belongs to pass c/48, phase c%48.
    task automatic follow_run(input bit noise, output int cyc);
        int ph, ps;
        logic [16:0] ectl;
        logic [63:0] ebw;
        cyc = 0;
        while (Busy === 1'b1 && cyc < 200) begin
            ps = cyc / 48;
            ph = cyc % 48;
            if (ph < 32) begin
                ectl = {1'b1, 1'b1, 5'(ph), 5'd0, 5'd0};
                ebw  = wdat(ps, ph);
            end else begin
                ectl = {1'b1, 1'b0, 5'd0, 5'(2 * (ph - 32)), 5'(2 * (ph - 32) + 1)};
                ebw  = 64'd0;
            end
            chk("cyc_ctl", 64'({Busy, RegWr, RW, RA, RB}), 64'(ectl));
            chk("cyc_busw", BusW, ebw);
            if (noise) Start = 1'($urandom % 2);
            tick();
            cyc++;
        end
    endtask

    task automatic check_result(input int cyc, input int m);
        int fc, ff;
        predict(m, rr, bb, vv, fc, ff);
        chk("busy_len", 64'(cyc), 64'd96);
        chk("done", 64'(Done), 64'd1);
        chk("pass", 64'(Pass), 64'(fc == 0));
        chk("failcount", 64'(FailCount), 64'(fc));
        if (fc != 0) chk("firstfail", 64'(FirstFailReg), 64'(ff));
    endtask

    task automatic run(input int m, input int sr, input int sb, input int sv, input bit noise);
        int cyc;
        mode = m; rr = sr; bb = sb; vv = sv;
        clear_rf();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        follow_run(noise, cyc);
        Start = 1'b0;
        check_result(cyc, m);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        vectors = 0; miscompares = 0;
        mode = 0; rr = 0; bb = 0; vv = 0;
        rf_clr = 1'b0; Start = 1'b0; Reset = 1'b1;
        repeat (2) tick();
        chk("rst_ctl", 64'({Busy, Done, Pass, RegWr, RA, RB, RW, FailCount, FirstFailReg}), 64'd0);
        chk("rst_busw", BusW, 64'd0);
        Reset = 1'b0;
        tick();

        run(0, 0, 0, 0, 1'b0);
        run(1, 5, 0, 1, 1'b0);
        run(2, 0, 0, 0, 1'b0);
        run(3, 0, 0, 0, 1'b0);
        run(0, 0, 0, 0, 1'b1);

        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            run(1, int'($urandom_range(0, 30)), int'($urandom_range(0, 63)),
                int'($urandom % 2), 1'b1);
        end

        // Reset in the middle of pass-0 writes
        mode = 0;
        clear_rf();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (10) tick();
        chk("pre_abort_rw", 64'({RegWr, RW}), 64'({1'b1, 5'd10}));
        #2 Reset = 1'b1;
        #1;
        chk("abort_ctl", 64'({Busy, Done, Pass, RegWr, RA, RB, RW, FailCount, FirstFailReg}), 64'd0);
        chk("abort_busw", BusW, 64'd0);
        tick();
        Reset = 1'b0;
        tick();
        run(0, 0, 0, 0, 1'b0);

        // Start held high: back-to-back runs with one Done cycle between
        mode = 0;
        clear_rf();
        Start = 1'b1;
        tick();
        follow_run(1'b0, cyc);
        chk("b2b_len1", 64'(cyc), 64'd96);
        chk("b2b_gap", 64'({Done, Busy, Pass}), 64'b101);
        tick();
        chk("b2b_restart", 64'({Done, Busy}), 64'b01);
        follow_run(1'b0, cyc);
        Start = 1'b0;
        check_result(cyc, 0);
        tick();
        chk("done_hold", 64'({Done, Busy}), 64'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
